// File: rtl/posit_decoder_if.sv
// ----------------------------------------------------------------------------
// posit_decoder_if
//   Handshake bundle between a posit word producer, the posit decoder, and the
//   field consumer (the posit adder-subtractor operand port).
//
//   Input side  : in_valid / in_ready / in_data (N-bit posit word)
//   Output side : out_valid / out_ready plus the decoded fields
//                 out_sign, out_le (signed scale), out_exp, out_mant,
//                 out_rlen (signed regime length), out_zero, out_nar
//
//   Modports
//     master : environment view (drives words, accepts fields)
//     slave  : decoder view
// ----------------------------------------------------------------------------
interface posit_decoder_if #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) ();

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_data;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [ES+RS:0]    out_le;
  logic [ES-1:0]     out_exp;
  logic [N-1:0]      out_mant;
  logic [RS:0]       out_rlen;
  logic              out_zero;
  logic              out_nar;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_le, out_exp,
           out_mant, out_rlen, out_zero, out_nar
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_le, out_exp,
           out_mant, out_rlen, out_zero, out_nar
  );

endinterface

// File: rtl/posit_decoder.sv
// ----------------------------------------------------------------------------
// posit_decoder
//   Two-stage pipelined posit unpacker. Splits an N-bit posit into sign,
//   signed scale (k*2^ES + exp), exponent, mantissa with hidden one at bit
//   N-1, and signed regime length. Zero and NaR are flagged with every other
//   field forced to zero.
//
//   Ports
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     bus        : posit_decoder_if.slave (valid/ready in, valid/ready out)
//   Optional (macro POSIT_DECODER_STATS_EN)
//     stat_clr       : synchronous clear of both counters
//     stat_zero_cnt  : saturating count of zero beats delivered
//     stat_nar_cnt   : saturating count of NaR beats delivered
//
//   Stage 1 registers sign, |word| and the zero/NaR flags.
//   Stage 2 registers the decoded fields. in_ready is combinational from
//   out_ready so a full pipeline can accept and drain in the same cycle.
// ----------------------------------------------------------------------------
module posit_decoder #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  posit_decoder_if.slave bus
`ifdef POSIT_DECODER_STATS_EN
  ,
  input  logic           stat_clr,
  output logic [15:0]    stat_zero_cnt,
  output logic [15:0]    stat_nar_cnt
`endif
);

  localparam int LW = ES + RS + 1;   // scale width
  localparam int FW = N - 1 - ES;    // fraction bits available after regime/exp

  // Magnitude of the word, only the N-1 body bits are needed downstream
  // (the MSB of |word| is set only for NaR, which is flagged separately).
  function automatic logic [N-2:0] body_abs(input logic [N-1:0] w);
    logic [N-2:0] b;
    if (w[N-1]) begin
      b = ~w[N-2:0] + {{(N-2){1'b0}}, 1'b1};
    end else begin
      b = w[N-2:0];
    end
    return b;
  endfunction

  // Length of the run of bits equal to the leading body bit (1..N-1).
  function automatic logic [RS:0] run_length(input logic [N-2:0] body);
    logic [N-2:0] x;
    logic [RS:0]  cnt;
    logic         found;
    // Invert a ones-run so both polarities reduce to a leading-zero count.
    if (body[N-2]) begin
      x = ~body;
    end else begin
      x = body;
    end
    cnt   = {(RS+1){1'b0}};
    found = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (found) begin
        cnt = cnt;
      end else if (x[i]) begin
        found = 1'b1;
      end else begin
        cnt = cnt + (RS+1)'(1);
      end
    end
    return cnt;
  endfunction

  logic           s1_valid_r;
  logic           s1_sign_r;
  logic           s1_zero_r;
  logic           s1_nar_r;
  logic [N-2:0]   s1_body_r;

  logic           s2_valid_r;
  logic           s2_sign_r;
  logic [LW-1:0]  s2_le_r;
  logic [ES-1:0]  s2_exp_r;
  logic [N-1:0]   s2_mant_r;
  logic [RS:0]    s2_rlen_r;
  logic           s2_zero_r;
  logic           s2_nar_r;

  logic           s1_load_s;
  logic           s2_load_s;
  logic           accept_s;

  logic [RS:0]    run_s;
  logic [RS:0]    shamt_s;
  logic [RS:0]    k_s;
  logic [RS:0]    rlen_s;
  logic [N-2:0]   tail_s;
  logic           d_sign_s;
  logic [LW-1:0]  d_le_s;
  logic [ES-1:0]  d_exp_s;
  logic [N-1:0]   d_mant_s;
  logic [RS:0]    d_rlen_s;

  // Pipeline advance: a stage loads when its slot is empty or being emptied.
  always_comb begin
    s2_load_s = ~s2_valid_r | bus.out_ready;
    s1_load_s = ~s1_valid_r | s2_load_s;
    accept_s  = bus.in_valid & s1_load_s;
  end

  assign bus.in_ready = s1_load_s;

  // Stage-1 register: sign, magnitude body and special-value flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_nar_r   <= 1'b0;
      s1_body_r  <= {(N-1){1'b0}};
    end else begin
      if (s1_load_s) begin
        s1_valid_r <= bus.in_valid;
      end
      if (accept_s) begin
        s1_sign_r <= bus.in_data[N-1];
        s1_body_r <= body_abs(bus.in_data);
        s1_zero_r <= (bus.in_data == {N{1'b0}});
        s1_nar_r  <= (bus.in_data == {1'b1, {(N-1){1'b0}}});
      end
    end
  end

  // Field extraction from the stage-1 magnitude body.
  always_comb begin
    run_s   = run_length(s1_body_r);
    shamt_s = run_s + (RS+1)'(1);
    // Drop regime and terminator; a shift of N-1 or more empties the tail,
    // which is exactly the maximum-run case (exp=0, empty fraction).
    tail_s  = s1_body_r << shamt_s;

    if (s1_body_r[N-2]) begin
      k_s = run_s - (RS+1)'(1);
    end else begin
      k_s = ~run_s + (RS+1)'(1);
    end

    // A run reaching bit 0 has no terminator bit.
    if (run_s == (RS+1)'(N - 1)) begin
      rlen_s = run_s;
    end else begin
      rlen_s = shamt_s;
    end

    d_sign_s = 1'b0;
    d_le_s   = {LW{1'b0}};
    d_exp_s  = {ES{1'b0}};
    d_mant_s = {N{1'b0}};
    d_rlen_s = {(RS+1){1'b0}};
    if (s1_zero_r | s1_nar_r) begin
      d_sign_s = 1'b0;
    end else begin
      d_sign_s = s1_sign_r;
      d_exp_s  = tail_s[N-2 -: ES];
      // Low ES bits of k<<<ES are zero, so the scale is a concatenation.
      d_le_s   = {k_s, tail_s[N-2 -: ES]};
      d_mant_s = {1'b1, tail_s[FW-1:0], {ES{1'b0}}};
      d_rlen_s = rlen_s;
    end
  end

  // Stage-2 register: decoded fields held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_le_r    <= {LW{1'b0}};
      s2_exp_r   <= {ES{1'b0}};
      s2_mant_r  <= {N{1'b0}};
      s2_rlen_r  <= {(RS+1){1'b0}};
      s2_zero_r  <= 1'b0;
      s2_nar_r   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sign_r <= d_sign_s;
        s2_le_r   <= d_le_s;
        s2_exp_r  <= d_exp_s;
        s2_mant_r <= d_mant_s;
        s2_rlen_r <= d_rlen_s;
        s2_zero_r <= s1_zero_r;
        s2_nar_r  <= s1_nar_r;
      end
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_sign  = s2_sign_r;
  assign bus.out_le    = s2_le_r;
  assign bus.out_exp   = s2_exp_r;
  assign bus.out_mant  = s2_mant_r;
  assign bus.out_rlen  = s2_rlen_r;
  assign bus.out_zero  = s2_zero_r;
  assign bus.out_nar   = s2_nar_r;

`ifdef POSIT_DECODER_STATS_EN
  logic        fire_s;
  logic [15:0] zero_cnt_r;
  logic [15:0] nar_cnt_r;

  assign fire_s = s2_valid_r & bus.out_ready;

  // Special-value counters: bump on delivered beats, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_r <= 16'h0000;
      nar_cnt_r  <= 16'h0000;
    end else if (stat_clr) begin
      zero_cnt_r <= 16'h0000;
      nar_cnt_r  <= 16'h0000;
    end else begin
      if (fire_s && s2_zero_r && (zero_cnt_r != 16'hFFFF)) begin
        zero_cnt_r <= zero_cnt_r + 16'h0001;
      end
      if (fire_s && s2_nar_r && (nar_cnt_r != 16'hFFFF)) begin
        nar_cnt_r <= nar_cnt_r + 16'h0001;
      end
    end
  end

  assign stat_zero_cnt = zero_cnt_r;
  assign stat_nar_cnt  = nar_cnt_r;
`endif

endmodule

// File: tb/tb_posit_decoder.sv
// ----------------------------------------------------------------------------
// tb_posit_decoder
//   Scoreboard bench for posit_decoder (N=32, ES=2). Expected field vectors
//   are pushed when a word is accepted and popped when a beat is delivered.
//   Packed vector layout: {sign, le[7:0], exp[1:0], mant[31:0], rlen[5:0],
//   zero, nar}.
// ----------------------------------------------------------------------------
module tb_posit_decoder;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = $clog2(N);

  typedef logic [50:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  posit_decoder_if #(.N(N), .ES(ES), .RS(RS)) bus ();

`ifdef POSIT_DECODER_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_zero_cnt;
  logic [15:0] stat_nar_cnt;
`endif

  posit_decoder #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef POSIT_DECODER_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_zero_cnt (stat_zero_cnt),
    .stat_nar_cnt  (stat_nar_cnt)
`endif
  );

  int   vectors = 0;
  int   errors  = 0;
  vec_t sb [$];
  vec_t exp_v;
  vec_t obs_v;

  function automatic vec_t pack(input logic s, input logic [7:0] le, input logic [1:0] e,
                                input logic [31:0] m, input logic [5:0] rl,
                                input logic z, input logic n);
    return {s, le, e, m, rl, z, n};
  endfunction

  function automatic vec_t observed();
    return {bus.out_sign, bus.out_le, bus.out_exp, bus.out_mant, bus.out_rlen,
            bus.out_zero, bus.out_nar};
  endfunction

  // Reference: walk the word bit by bit from the top.
  function automatic vec_t model(input logic [31:0] w);
    logic [31:0] a;
    logic [31:0] m;
    logic        r0;
    int i, run, k, e, le, rl;
    if (w == 32'h00000000) return pack(1'b0, 8'd0, 2'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    if (w == 32'h80000000) return pack(1'b0, 8'd0, 2'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    a   = w[31] ? (~w + 32'd1) : w;
    r0  = a[30];
    i   = 30;
    run = 0;
    while (i >= 0 && a[i] == r0) begin
      run++;
      i--;
    end
    k = r0 ? (run - 1) : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    m = 32'h80000000;
    for (int p = 30; p >= 0; p--) begin
      if (i >= 0) begin
        m[p] = a[i];
        i--;
      end
    end
    le = k * 4 + e;
    rl = (run + 1 > 31) ? 31 : run + 1;
    return pack(w[31], 8'(le), 2'(e), m, 6'(rl), 1'b0, 1'b0);
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_valid: out_valid=%b required 0", bus.out_valid);
      errors++;
    end
    vectors++;
    if (observed() !== 51'd0) begin
      $display("FAIL reset_fields: got %h required 0", observed());
      errors++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
      errors++;
    end
`ifdef POSIT_DECODER_STATS_EN
    vectors++;
    if (stat_zero_cnt !== 16'd0 || stat_nar_cnt !== 16'd0) begin
      $display("FAIL reset_stats: zero=%0d nar=%0d required 0/0", stat_zero_cnt, stat_nar_cnt);
      errors++;
    end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] dw [10];
    vec_t        de [10];
    int fed = 0;
    int cyc = 0;
    dw[0] = 32'h40000000; de[0] = pack(1'b0, 8'd1 - 8'd1, 2'd0, 32'h80000000, 6'd2, 1'b0, 1'b0);
    dw[1] = 32'h48000000; de[1] = pack(1'b0, 8'd1, 2'd1, 32'h80000000, 6'd2, 1'b0, 1'b0);
    dw[2] = 32'hC0000000; de[2] = pack(1'b1, 8'd0, 2'd0, 32'h80000000, 6'd2, 1'b0, 1'b0);
    dw[3] = 32'h7FFFFFFF; de[3] = pack(1'b0, 8'd120, 2'd0, 32'h80000000, 6'd31, 1'b0, 1'b0);
    dw[4] = 32'h00000001; de[4] = pack(1'b0, 8'h88, 2'd0, 32'h80000000, 6'd31, 1'b0, 1'b0);
    dw[5] = 32'h00000000; de[5] = pack(1'b0, 8'd0, 2'd0, 32'h0, 6'd0, 1'b1, 1'b0);
    dw[6] = 32'h80000000; de[6] = pack(1'b0, 8'd0, 2'd0, 32'h0, 6'd0, 1'b0, 1'b1);
    dw[7] = 32'h4C000000; de[7] = pack(1'b0, 8'd1, 2'd1, 32'hC0000000, 6'd2, 1'b0, 1'b0);
    dw[8] = 32'hB4000000; de[8] = pack(1'b1, 8'd1, 2'd1, 32'hC0000000, 6'd2, 1'b0, 1'b0);
    dw[9] = 32'h30000000; de[9] = pack(1'b0, 8'hFE, 2'd2, 32'h80000000, 6'd2, 1'b0, 1'b0);
    while ((fed < 10 || sb.size() > 0) && cyc < 40) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 10);
      bus.in_data   = (fed < 10) ? dw[fed] : 32'h0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          $display("FAIL directed_spurious: unexpected beat %h", observed());
          errors++;
        end else begin
          exp_v = sb.pop_front();
          obs_v = observed();
          if (obs_v !== exp_v) begin
            $display("FAIL directed_fields: got %h required %h", obs_v, exp_v);
            errors++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(de[fed]);
        fed++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (fed != 10 || sb.size() != 0) begin
      $display("FAIL directed_timeout: fed=%0d pending=%0d required 10/0", fed, sb.size());
      errors++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    int fed = 0;
    int nfire = 0;
    int first_fire = -1;
    int last_fire = -1;
    int cyc = 0;
    w[0] = 32'h5A3C1234;
    w[1] = 32'hA1B2C3D4;
    w[2] = 32'h12345678;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 3);
      bus.in_data   = w[(fed < 3) ? fed : 2];
      bus.out_ready = 1'b0;
      #1;
      vectors++;
      if (bus.in_ready !== ((c < 2) ? 1'b1 : 1'b0)) begin
        $display("FAIL bp_in_ready: cycle %0d in_ready=%b required %b", c, bus.in_ready, (c < 2));
        errors++;
      end
      if (c >= 2) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0 || observed() !== sb[0]) begin
          $display("FAIL bp_hold: cycle %0d valid=%b fields=%h", c, bus.out_valid, observed());
          errors++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_data));
        fed++;
      end
    end
    vectors++;
    if (fed != 2) begin
      $display("FAIL bp_accepts: accepted=%0d required 2", fed);
      errors++;
    end
    while ((fed < 3 || sb.size() > 0) && cyc < 20) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 3);
      bus.in_data   = w[(fed < 3) ? fed : 2];
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        nfire++;
        if (sb.size() == 0) begin
          $display("FAIL bp_spurious: unexpected beat %h", observed());
          errors++;
        end else begin
          exp_v = sb.pop_front();
          obs_v = observed();
          if (obs_v !== exp_v) begin
            $display("FAIL bp_order: got %h required %h", obs_v, exp_v);
            errors++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_data));
        fed++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (nfire != 3 || (last_fire - first_fire) != 2 || sb.size() != 0) begin
      $display("FAIL bp_drain: beats=%0d span=%0d pending=%0d required 3/2/0",
               nfire, last_fire - first_fire, sb.size());
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rw [8];
    int fed = 0;
    int cyc = 0;
    int a0 = -1;
    int first_fire = -1;
    int last_fire = -1;
    int nfire = 0;
    int gaps = 0;
    for (int i = 0; i < 8; i++) rw[i] = $urandom();
    while ((fed < 8 || sb.size() > 0) && cyc < 30) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 8);
      bus.in_data   = rw[(fed < 8) ? fed : 7];
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (first_fire < 0) first_fire = cyc;
        if (last_fire >= 0 && cyc != last_fire + 1) gaps++;
        last_fire = cyc;
        nfire++;
        if (sb.size() == 0) begin
          $display("FAIL b2b_spurious: unexpected beat %h", observed());
          errors++;
        end else begin
          exp_v = sb.pop_front();
          obs_v = observed();
          if (obs_v !== exp_v) begin
            $display("FAIL b2b_fields: got %h required %h", obs_v, exp_v);
            errors++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (a0 < 0) a0 = cyc;
        sb.push_back(model(bus.in_data));
        fed++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (nfire != 8 || gaps != 0 || first_fire != a0 + 2) begin
      $display("FAIL b2b_stream: beats=%0d gaps=%0d first=%0d required 8/0/%0d",
               nfire, gaps, first_fire, a0 + 2);
      errors++;
    end
  endtask

  task automatic test_reset_midstream();
    int fed = 0;
    int stale = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 2);
      bus.in_data   = (fed == 0) ? 32'h48000000 : 32'h7FFFFFFF;
      bus.out_ready = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_data));
        fed++;
      end
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL mid_inflight: out_valid=%b required 1", bus.out_valid);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL mid_reset_valid: out_valid=%b required 0", bus.out_valid);
      errors++;
    end
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    vectors++;
    if (stale != 0) begin
      $display("FAIL mid_stale: stale beats=%0d required 0", stale);
      errors++;
    end
  endtask

`ifdef POSIT_DECODER_STATS_EN
  task automatic test_stats();
    logic [31:0] sw [5];
    int fed = 0;
    int cyc = 0;
    sw[0] = 32'h00000000;
    sw[1] = 32'h00000000;
    sw[2] = 32'h80000000;
    sw[3] = 32'h00000000;
    sw[4] = 32'h80000000;
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    while ((fed < 5 || sb.size() > 0) && cyc < 30) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (fed < 5);
      bus.in_data   = sw[(fed < 5) ? fed : 4];
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 51'h7FFFFFFFFFFFF;
        obs_v = observed();
        if (obs_v !== exp_v) begin
          $display("FAIL stats_fields: got %h required %h", obs_v, exp_v);
          errors++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_data));
        fed++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    vectors++;
    if (stat_zero_cnt !== 16'd3 || stat_nar_cnt !== 16'd2) begin
      $display("FAIL stats_count: zero=%0d nar=%0d required 3/2", stat_zero_cnt, stat_nar_cnt);
      errors++;
    end
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    #1;
    vectors++;
    if (stat_zero_cnt !== 16'd0 || stat_nar_cnt !== 16'd0) begin
      $display("FAIL stats_clear: zero=%0d nar=%0d required 0/0", stat_zero_cnt, stat_nar_cnt);
      errors++;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
`ifdef POSIT_DECODER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
